// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC and fetches over a req/ack instruction port.
// Presents one instruction at a time to decode; branch redirect kills and flushes.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            Branch,
  input  logic [XLEN-1:0] Target,
  input  logic            Stall,
  output logic            IMemReq,
  output logic [XLEN-1:0] IMemAddr,
  input  logic            IMemAck,
  input  logic [XLEN-1:0] IMemData,
  output logic [XLEN-1:0] Instr,
  output logic [XLEN-1:0] InstrPC,
  output logic            InstrValid,
  output logic            Flush
);

  typedef enum logic [1:0] {
    START,
    FETCH,
    VALID
  } state_t;

  state_t state, state_n;

  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] addr_n;
  logic [XLEN-1:0] instr_n;
  logic [XLEN-1:0] ipc_n;
  logic            discard, discard_n;
  logic            req_n;
  logic            valid_n;
  logic            flush_n;

  assign tgt = Target & ~(XLEN'(3));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= START;
      pc         <= RESET_PC;
      discard    <= 1'b0;
      IMemReq    <= 1'b0;
      IMemAddr   <= '0;
      Instr      <= '0;
      InstrPC    <= '0;
      InstrValid <= 1'b0;
      Flush      <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      discard    <= discard_n;
      IMemReq    <= req_n;
      IMemAddr   <= addr_n;
      Instr      <= instr_n;
      InstrPC    <= ipc_n;
      InstrValid <= valid_n;
      Flush      <= flush_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    discard_n = discard;
    req_n     = IMemReq;
    addr_n    = IMemAddr;
    instr_n   = Instr;
    ipc_n     = InstrPC;
    valid_n   = InstrValid;
    flush_n   = 1'b0;

    unique case (state)
      START: begin
        if (Branch) begin
          pc_n    = tgt;
          flush_n = 1'b1;
        end else begin
          req_n   = 1'b1;
          addr_n  = pc;
          state_n = FETCH;
        end
      end

      FETCH: begin
        if (Branch) begin
          pc_n    = tgt;
          flush_n = 1'b1;
          valid_n = 1'b0;
          // Without an ack the request must stay put; remember to drop it.
          if (IMemAck) begin
            discard_n = 1'b0;
            req_n     = 1'b1;
            addr_n    = tgt;
          end else begin
            discard_n = 1'b1;
          end
        end else if (IMemAck) begin
          if (discard) begin
            discard_n = 1'b0;
            req_n     = 1'b1;
            addr_n    = pc;
          end else begin
            instr_n = IMemData;
            ipc_n   = IMemAddr;
            valid_n = 1'b1;
            pc_n    = pc + XLEN'(4);
            req_n   = 1'b0;
            state_n = VALID;
          end
        end
      end

      VALID: begin
        if (Branch) begin
          pc_n    = tgt;
          flush_n = 1'b1;
          valid_n = 1'b0;
          req_n   = 1'b1;
          addr_n  = tgt;
          state_n = FETCH;
        end else if (!Stall) begin
          valid_n = 1'b0;
          req_n   = 1'b1;
          addr_n  = pc;
          state_n = FETCH;
        end
      end

      default: begin
        state_n = START;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized stimulus with a redirect scoreboard and PC-stream model.
// Memory responds with random latency; monitor checks presentations, flush and protocol.
module tb_fetch_unit;

  localparam int unsigned     XLEN = 32;
  localparam logic [XLEN-1:0] RPC  = '0;

  logic            CLK = 1'b0;
  logic            RESET = 1'b1;
  logic            Branch = 1'b0;
  logic [XLEN-1:0] Target = '0;
  logic            Stall = 1'b0;
  logic            IMemAck = 1'b0;
  logic [XLEN-1:0] IMemData = '0;
  logic            IMemReq;
  logic [XLEN-1:0] IMemAddr;
  logic [XLEN-1:0] Instr;
  logic [XLEN-1:0] InstrPC;
  logic            InstrValid;
  logic            Flush;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .Branch(Branch),
    .Target(Target),
    .Stall(Stall),
    .IMemReq(IMemReq),
    .IMemAddr(IMemAddr),
    .IMemAck(IMemAck),
    .IMemData(IMemData),
    .Instr(Instr),
    .InstrPC(InstrPC),
    .InstrValid(InstrValid),
    .Flush(Flush)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int              c;
    logic [XLEN-1:0] t;
  } redir_t;

  redir_t          rq[$];
  logic [XLEN-1:0] exp_pc;
  bit              mon_en = 1'b0;
  int              presented = 0;

  function automatic logic [XLEN-1:0] memfn(input logic [XLEN-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: random 0..3 cycle latency, spurious acks while idle, late ack in reset.
  int mcnt = 0;
  int mlat = 1;
  always @(posedge CLK) begin
    #1;
    if (RESET) begin
      IMemAck  = 1'b1;
      IMemData = 32'hDEAD_BEEF;
      mcnt     = 0;
    end else if (IMemReq) begin
      if (mcnt >= mlat) begin
        IMemAck  = 1'b1;
        IMemData = memfn(IMemAddr);
        mcnt     = 0;
        mlat     = $urandom_range(0, 3);
      end else begin
        IMemAck  = 1'b0;
        IMemData = $urandom;
        mcnt++;
      end
    end else begin
      IMemAck  = ($urandom_range(0, 7) == 0);
      IMemData = $urandom;
      mcnt     = 0;
    end
  end

  // Monitor
  logic            pv = 1'b0;
  logic [XLEN-1:0] ppc = '0;
  logic [XLEN-1:0] pins = '0;
  logic            pst = 1'b0;
  logic            pbr = 1'b0;
  logic            preq = 1'b0;
  logic            pack = 1'b0;
  logic [XLEN-1:0] paddr = '0;
  logic            fl;

  always @(negedge CLK) begin
    if (mon_en) begin
      fl = 1'b0;
      if (rq.size() > 0 && rq[0].c == cyc) begin
        fl     = 1'b1;
        exp_pc = rq[0].t;
        void'(rq.pop_front());
      end
      check("flush", {31'b0, Flush}, {31'b0, fl});
      if (fl)
        check("kill_valid", {31'b0, InstrValid}, 32'd0);
      if (InstrValid && !pv) begin
        check("instr_pc", InstrPC, exp_pc);
        check("instr_data", Instr, memfn(exp_pc));
        exp_pc = exp_pc + 32'd4;
        presented++;
      end
      if (InstrValid && pv) begin
        check("hold_pc", InstrPC, ppc);
        check("hold_instr", Instr, pins);
      end
      if (InstrValid)
        check("no_req_in_valid", {31'b0, IMemReq}, 32'd0);
      if (pv && !pst && !pbr)
        check("consume", {31'b0, InstrValid}, 32'd0);
      if (preq && !pack) begin
        check("req_held", {31'b0, IMemReq}, 32'd1);
        check("addr_stable", IMemAddr, paddr);
      end
    end
    pv    = InstrValid;
    ppc   = InstrPC;
    pins  = Instr;
    pst   = Stall;
    pbr   = Branch;
    preq  = IMemReq;
    pack  = IMemAck;
    paddr = IMemAddr;
  end

  task automatic check_zero();
    check("rst_req", {31'b0, IMemReq}, 32'd0);
    check("rst_addr", IMemAddr, 32'd0);
    check("rst_instr", Instr, 32'd0);
    check("rst_ipc", InstrPC, 32'd0);
    check("rst_valid", {31'b0, InstrValid}, 32'd0);
    check("rst_flush", {31'b0, Flush}, 32'd0);
  endtask

  task automatic release_and_start();
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("start_no_req", {31'b0, IMemReq}, 32'd0);
    @(negedge CLK);
    check("first_req", {31'b0, IMemReq}, 32'd1);
    check("first_addr", IMemAddr, RPC);
    @(posedge CLK);
    #1;
    rq.delete();
    exp_pc = RPC;
    mon_en = 1'b1;
  endtask

  task automatic run_random(input int n, input int wrap_at);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      Stall  = ($urandom_range(0, 2) == 0);
      Branch = ($urandom_range(0, 11) == 0);
      Target = $urandom;
      if (i == wrap_at) begin
        Branch = 1'b1;
        Target = 32'hFFFF_FFF3;
      end
      if (i == wrap_at + 1)
        Branch = 1'b0;
      if (i > wrap_at && i < wrap_at + 40)
        Branch = 1'b0;
      if (Branch)
        rq.push_back('{cyc + 1, Target & ~32'h3});
    end
    @(posedge CLK);
    #1;
    Branch = 1'b0;
    Stall  = 1'b0;
  endtask

  initial begin
    bit found;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #2;
    check_zero();
    release_and_start();
    run_random(3000, 1500);

    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge CLK);
      if (IMemReq && !IMemAck) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL wait_req: got no pending request within 20 cycles");
    end
    #2;
    mon_en = 1'b0;
    RESET  = 1'b1;
    #1;
    check_zero();
    release_and_start();
    run_random(300, 1000);
    repeat (4) @(posedge CLK);
    mon_en = 1'b0;

    tests++;
    if (presented < 100) begin
      fails++;
      $display("FAIL throughput: got %0d presentations expected at least 100", presented);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
